frame_stream_out: RTL
=====================

Name: frame_stream_out

Overview:
- Downstream stage of the sequential bilinear downscaler.
- Detects the downscaler's frame-complete level (`done`) and snapshots the reduced DST_H x DST_W image into an internal frame buffer.
- Streams the image one pixel per beat, in raster order, over a valid/ready interface with SOF/EOL/EOF markers, towards the display/UART/memory writer.
- Because of the snapshot, the downscaler can start its next frame while the current one is still streaming.

Parameters:
- IMG_H, 3, image rows (matches the downscaler's DST_H).
- IMG_W, 3, image columns (matches the downscaler's DST_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- frame_valid  input  1  frame-ready level; driven by the downscaler `done`.
- frame_in  input  8 x [IMG_H][IMG_W]  unpacked pixel array; driven by the downscaler `image_out`.
- m_valid  output  1  pixel beat valid.
- m_ready  input  1  consumer ready.
- m_data  output  8  pixel value.
- m_sof  output  1  first pixel of frame (row 0, col 0).
- m_eol  output  1  last pixel of row (col IMG_W-1).
- m_eof  output  1  last pixel of frame (row IMG_H-1, col IMG_W-1).
- busy  output  1  frame held in buffer, not yet fully sent.
- frame_drop  output  1  one-cycle pulse: a frame was discarded.
- drop_count  output  8  saturating count of discarded frames.

Behaviour:
- Reset and clocking:
  - Single clock domain.
  - The reset is one clock; asynchronous and active-low. While rst=0: m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, busy=0, frame_drop=0, drop_count=0, buffer cleared to 0, row/col=0, state=S_IDLE, fv_q=1.
  - fv_q resets to 1 so that a frame_valid level held across reset is not captured as a new frame.
- Frame edge: fv_q <= frame_valid each cycle; fv_rise = frame_valid & ~fv_q.
- States: S_IDLE, S_STREAM.
- S_IDLE:
  - m_valid=0 and markers 0.
  - On fv_rise: copy all of frame_in into the buffer, row=col=0, go to S_STREAM.
  - m_valid=1 in the cycle after the capturing edge, so capture-to-first-beat latency is 1 cycle.
- S_STREAM:
  - m_valid=1, busy=1.
  - m_data=buf[row][col]; markers are decoded from row/col.
  - Outputs are derived only from registers, never combinationally from m_ready.
- Handshake:
  - A beat transfers when m_valid & m_ready.
  - Without a transfer, m_data and the markers hold stable.
  - On a transfer: if col==IMG_W-1 then col=0, row++; else col++.
- Last beat (row=IMG_H-1, col=IMG_W-1, transfer):
  - If fv_rise in the same cycle: capture the new frame, row=col=0, stay in S_STREAM. There is no bubble, and the next beat carries m_sof.
  - Otherwise: go to S_IDLE; m_valid=0 and busy=0 the next cycle.
- fv_rise in S_STREAM that is not coincident with the last-beat transfer:
  - The frame is dropped and the buffer is untouched.
  - frame_drop=1 for one cycle.
  - drop_count increments, saturating at 255.
- frame_valid held high does not cause a recapture; only rising edges count.
- A rise while m_ready is held low is a drop and does not stall the stream.
- Async reset asserted mid-frame: the stream aborts immediately and all outputs go to their reset values. No partial frame resumes after release.
- Width rules:
  - row width = $clog2(IMG_H)+1.
  - col width = $clog2(IMG_W)+1.
  - Comparisons are against IMG_H-1 and IMG_W-1. Counters never exceed these.

Test Plan:
- Reset hold with frame_valid=1, then release with no falling edge -> no capture; m_valid stays 0 and busy=0 for 20 cycles.
- frame_in=10..90 (row-major, step 10), frame_valid pulse, m_ready=1 ->
  - 9 consecutive beats 10,20,...,90;
  - m_sof on beat 1; m_eol on beats 3,6,9; m_eof on beat 9;
  - first beat 1 cycle after the edge; m_valid=0 after beat 9.
- Same frame, m_ready toggled 1,0,0,1,... -> m_data/markers stable during stalls; sequence identical to the previous test; no beat duplicated or lost.
- Second frame (values 1..9) with its rise coincident with the frame-1 last-beat transfer -> beat 10 = 1 with m_sof, no idle cycle, frame_drop=0.
- Rise at beat 4 of an in-progress frame -> frame_drop one-cycle pulse, drop_count=1, remaining beats 40..90 unchanged; 300 such drops -> drop_count=255.
- rst asserted at beat 5 -> all outputs 0 asynchronously; after release plus a new rise, the stream restarts from m_sof with the newly captured data.

Source files
------------

// File: rtl/frame_stream_out_if.sv
// Pixel stream bus: one 8-bit pixel per beat, valid/ready handshake,
// with start-of-frame, end-of-line and end-of-frame markers.
interface frame_stream_out_if;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       m_eof;

    modport master (
        output m_valid,
        output m_data,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );
endinterface

// File: rtl/frame_stream_out.sv
// Downstream stage of the bilinear downscaler. It snapshots a finished
// IMG_H x IMG_W image on the rising edge of frame_valid and streams it out
// in raster order, one pixel per beat. The snapshot frees the downscaler
// to work on the next frame while this one drains. Rising edges that
// arrive mid-stream are dropped and counted; a rise coincident with the
// last-beat transfer is taken without a bubble.
module frame_stream_out #(
    parameter int IMG_H = 3,
    parameter int IMG_W = 3
) (
    input  logic                clk,
    input  logic                rst,          // asynchronous, active-low
    input  logic                frame_valid,
    input  logic [7:0]          frame_in [IMG_H][IMG_W],
    frame_stream_out_if.master  m,
    output logic                busy,
    output logic                frame_drop,
    output logic [7:0]          drop_count
);

    localparam int RW  = $clog2(IMG_H) + 1;
    localparam int CW  = $clog2(IMG_W) + 1;
    // Index bits actually needed to address the buffer dimensions.
    localparam int RIW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CIW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [0:0] {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t         state_q;
    logic [RW-1:0]  row_q;
    logic [CW-1:0]  col_q;
    logic           fv_q;
    logic [7:0]     buf_q [IMG_H][IMG_W];
    logic           m_valid_q;
    logic [7:0]     m_data_q;
    logic           m_sof_q;
    logic           m_eol_q;
    logic           m_eof_q;
    logic           frame_drop_q;
    logic [7:0]     drop_count_q;

    logic           fv_rise;
    logic           fire;
    logic           at_last_col;
    logic           at_last;
    logic           load;
    logic           drop_d;
    logic [RW-1:0]  nxt_row;
    logic [CW-1:0]  nxt_col;

    // Edge detect, handshake and raster-position helpers, all from registers.
    assign fv_rise     = frame_valid & ~fv_q;
    assign fire        = m_valid_q & m.m_ready;
    assign at_last_col = (col_q == CW'(IMG_W - 1));
    assign at_last     = at_last_col & (row_q == RW'(IMG_H - 1));
    assign nxt_col     = at_last_col ? '0 : col_q + CW'(1);
    assign nxt_row     = at_last_col ? row_q + RW'(1) : row_q;

    // A new frame is taken when idle, or when the current frame's last beat
    // leaves in the same cycle; any other rise while streaming is dropped.
    assign load   = fv_rise & ((state_q == S_IDLE) | (fire & at_last));
    assign drop_d = fv_rise & (state_q == S_STREAM) & ~(fire & at_last);

    // Frame-edge register: reset high so a level held through reset is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fv_q <= 1'b1;
        else      fv_q <= frame_valid;
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_drop_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            frame_drop_q <= drop_d;
            if (drop_d && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
        end
    end

    // Frame buffer snapshot.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the buffer is small and its reset contents are observable as
        // all-zero, so it is cleared here; large RAMs would normally be left
        // unreset so they can map onto memory macros.
        if (!rst)      buf_q <= '{default: '0};
        else if (load) buf_q <= frame_in;
    end

    // Streaming FSM with registered beat outputs (data and markers are the
    // value for the position being entered, so nothing depends on m_ready
    // combinationally).
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else if (load) begin
            state_q   <= S_STREAM;
            row_q     <= '0;
            col_q     <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= frame_in[0][0];
            m_sof_q   <= 1'b1;
            m_eol_q   <= (IMG_W == 1);
            m_eof_q   <= (IMG_W == 1) && (IMG_H == 1);
        end else if (state_q == S_STREAM && fire) begin
            if (at_last) begin
                state_q   <= S_IDLE;
                row_q     <= '0;
                col_q     <= '0;
                m_valid_q <= 1'b0;
                m_data_q  <= '0;
                m_sof_q   <= 1'b0;
                m_eol_q   <= 1'b0;
                m_eof_q   <= 1'b0;
            end else begin
                row_q    <= nxt_row;
                col_q    <= nxt_col;
                m_data_q <= buf_q[nxt_row[RIW-1:0]][nxt_col[CIW-1:0]];
                m_sof_q  <= 1'b0;
                m_eol_q  <= (nxt_col == CW'(IMG_W - 1));
                m_eof_q  <= (nxt_col == CW'(IMG_W - 1)) && (nxt_row == RW'(IMG_H - 1));
            end
        end
    end

    assign m.m_valid  = m_valid_q;
    assign m.m_data   = m_data_q;
    assign m.m_sof    = m_sof_q;
    assign m.m_eol    = m_eol_q;
    assign m.m_eof    = m_eof_q;
    assign busy       = (state_q == S_STREAM);
    assign frame_drop = frame_drop_q;
    assign drop_count = drop_count_q;

endmodule
